pattern_seq_gen: RTL

//  Parametrised, programmable output-pattern sequencer.
//  - Generalises the fixed 3-bit pattern toggler: replays a RAM table of WIDTH-bit patterns.
//  - Per-step hold time, one-shot or looping playback, start/stop/done handshake.
//  - Drives test/stimulus buses and LED/IO patterns; sits directly on the system clock.

---
 rtl/pattern_seq_gen.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pattern_seq_gen.sv
// Programmable pattern sequencer: replays a table of WIDTH-bit patterns with per-step hold,
// one-shot or looping playback. Optional bidirectional walk enabled by PATSEQ_PINGPONG_EN.
module pattern_seq_gen #(
   parameter int WIDTH     = 3,
   parameter int DEPTH     = 8,
   parameter int DIVW      = 8,
   parameter int RESET_PAT = 5,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [WIDTH-1:0] cfg_data,
   input  logic [AW-1:0]    len,
   input  logic [DIVW-1:0]  step_div,
   input  logic             loop,
   input  logic             pingpong,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] pat_out,
   output logic             pat_valid,
   output logic             busy,
   output logic             done,
   output logic             dbg_state
);

   // Handshake: start is a level sampled only in IDLE (stop in the same cycle wins);
   // stop aborts RUN on the next edge; done is a single-cycle pulse after a one-shot completes.
   localparam logic [WIDTH-1:0] RST_PAT = WIDTH'(RESET_PAT);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    idx_q, idx_d, len_q, len_d, nxt_idx;
   logic [DIVW-1:0]  cnt_q, cnt_d, div_q, div_d;
   logic             loop_q, loop_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic             done_q, done_d;
   logic             pass_end;

`ifdef PATSEQ_PINGPONG_EN
   logic pp_q, pp_d, dir_down_q, dir_down_d, nxt_dir_down;
`else
   logic pingpong_unused;
   assign pingpong_unused = pingpong;
`endif

   // Table: asynchronous read, so a write landing on the fetch edge still yields old data.
   always_ff @(posedge clk) begin
      if (cfg_we) mem_q[cfg_addr] <= cfg_data;
   end

   // Index stepper: where playback goes after the current entry's hold expires.
   always_comb begin
      pass_end = (idx_q == len_q);
      nxt_idx  = pass_end ? '0 : idx_q + 1'b1;
`ifdef PATSEQ_PINGPONG_EN
      nxt_dir_down = dir_down_q;
      if (pp_q && (len_q != '0)) begin
         if (!dir_down_q) begin
            pass_end = 1'b0;
            if (idx_q == len_q) begin
               nxt_idx      = idx_q - 1'b1;
               nxt_dir_down = 1'b1;
            end else begin
               nxt_idx = idx_q + 1'b1;
            end
         end else begin
            pass_end = (idx_q == '0);
            if (idx_q == '0) begin
               nxt_idx      = AW'(1);
               nxt_dir_down = 1'b0;
            end else begin
               nxt_idx = idx_q - 1'b1;
            end
         end
      end
`endif
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         div_q   <= '0;
         loop_q  <= 1'b0;
         pat_q   <= RST_PAT;
         done_q  <= 1'b0;
`ifdef PATSEQ_PINGPONG_EN
         pp_q       <= 1'b0;
         dir_down_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         div_q   <= div_d;
         loop_q  <= loop_d;
         pat_q   <= pat_d;
         done_q  <= done_d;
`ifdef PATSEQ_PINGPONG_EN
         pp_q       <= pp_d;
         dir_down_q <= dir_down_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      div_d   = div_q;
      loop_d  = loop_q;
      pat_d   = pat_q;
      done_d  = 1'b0;
`ifdef PATSEQ_PINGPONG_EN
      pp_d       = pp_q;
      dir_down_d = dir_down_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_RUN;
               idx_d   = '0;
               cnt_d   = '0;
               len_d   = len;
               div_d   = step_div;
               loop_d  = loop;
               pat_d   = mem_q[0];
`ifdef PATSEQ_PINGPONG_EN
               pp_d       = pingpong;
               dir_down_d = 1'b0;
`endif
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
               pat_d   = RST_PAT;
            end else if (cnt_q != div_q) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               if (pass_end && !loop_q) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  pat_d   = RST_PAT;
                  done_d  = 1'b1;
               end else begin
                  idx_d = nxt_idx;
                  pat_d = mem_q[nxt_idx];
`ifdef PATSEQ_PINGPONG_EN
                  dir_down_d = nxt_dir_down;
`endif
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      pat_out   = pat_q;
      pat_valid = (state_q == ST_RUN);
      busy      = (state_q == ST_RUN);
      done      = done_q;
      dbg_state = state_q;
   end

endmodule
